// File: rtl/pc_stack.sv
// Hack CPU program counter with increment, jump, synchronous clear and an
// optional return-address stack (enabled by defining PC_STACK_EN).
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_CLR
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc = pc + WIDTH'(1);
  assign out    = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else begin
      pc <= pc_d;
    end
  end

`ifdef PC_STACK_EN
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [SW-1:0]    sp;
  logic [SW-1:0]    sp_d;
  logic             err;
  logic             err_d;
  logic             push;
  logic             full;
  logic             empty;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign full        = (sp == SW'(DEPTH));
  assign empty       = (sp == '0);
  assign wr_idx      = sp[AW-1:0];
  assign rd_idx      = wr_idx - AW'(1);
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err;

  // ret outranks load, so ret+load+call performs only the pop
  always_comb begin
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLR;
    end else if (ret) begin
      op = OP_RET;
    end else if (load && call) begin
      op = OP_CALL;
    end else if (load) begin
      op = OP_LOAD;
    end else if (inc) begin
      op = OP_INC;
    end
  end

  always_comb begin
    pc_d  = pc;
    sp_d  = sp;
    err_d = err;
    push  = 1'b0;
    case (op)
      OP_CLR: begin
        pc_d  = '0;
        sp_d  = '0;
        err_d = 1'b0;
      end
      OP_RET: begin
        if (!empty) begin
          pc_d = stack[rd_idx];
          sp_d = sp - SW'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      OP_CALL: begin
        pc_d = in;
        if (!full) begin
          push = 1'b1;
          sp_d = sp + SW'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      OP_LOAD: pc_d = in;
      OP_INC:  pc_d = pc_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      err <= 1'b0;
    end else begin
      sp  <= sp_d;
      err <= err_d;
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset
  always_ff @(posedge clk) begin
    if (push) begin
      stack[wr_idx] <= pc_inc;
    end
  end

`else
  logic unused_cfg;

  assign unused_cfg  = ^{call, ret, DEPTH != 0};
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign stack_err   = 1'b0;

  always_comb begin
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (inc) begin
      op = OP_INC;
    end
  end

  always_comb begin
    pc_d = pc;
    case (op)
      OP_CLR:  pc_d = '0;
      OP_LOAD: pc_d = in;
      OP_INC:  pc_d = pc_inc;
      default: ;
    endcase
  end
`endif

endmodule

// File: doc/pc_stack.md
# pc_stack

Program-counter stage for the Hack CPU datapath. It registers the next instruction address that the upstream 16-bit address mux selects and supports increment, load (jump) and synchronous clear. An optional return-address stack adds hardware call/return. Its output drives the instruction ROM address and feeds back into the upstream Mux16 as the sequential-path operand.

## Interface
- WIDTH, 16, address width in bits.
- DEPTH, 4, return-stack entries; a power of two, 2..16.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of PC and stack (Hack "reset" pin).
- load  input  1  load `in` into PC (jump).
- inc  input  1  increment PC.
- call  input  1  qualifies `load`: also push the return address.
- ret  input  1  pop the return stack into PC.
- in  input  WIDTH  jump target from the upstream Mux16.
- out  output  WIDTH  current PC.
- stack_full  output  1  stack holds DEPTH entries.
- stack_empty  output  1  stack holds 0 entries.
- stack_err  output  1  sticky overflow/underflow flag.

## Operation
- State: `pc` register (WIDTH), stack array DEPTH×WIDTH, `sp` count 0..DEPTH, `err` bit.
- Per-edge priority, highest first:
  - clr: pc←0, sp←0, err←0.
  - ret: if sp>0, pc←stack[sp-1] and sp←sp-1. If sp==0, pc holds and err←1.
  - load: pc←in. If call=1 and sp<DEPTH, stack[sp]←pc+1 (mod 2^WIDTH) and sp←sp+1. If call=1 and sp==DEPTH, pc←in still, no push, err←1.
  - inc: pc←pc+1, wrapping 0xFFFF→0x0000 with no flag.
  - none: hold.
- call without load is ignored. Lower-priority inputs are ignored on any cycle where a higher one is active.
- ret has priority over load: ret+load+call performs only the pop.
- Return address is pc+1, the instruction after the calling jump. At pc=0xFFFF the pushed value is 0x0000.
- err is sticky and cleared only by clr or rst_n.
- Arithmetic is modulo 2^WIDTH and never saturates.

## Timing
- All state updates on the rising edge of clk. Latency is 1 cycle: out reflects the control inputs of the previous edge.
- stack_full = (sp==DEPTH), stack_empty = (sp==0), both decoded combinationally from registered sp. stack_err = registered err.
- rst_n low, at any time and mid-operation: immediately out=0, sp=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents are don't-care.
- Release of rst_n is synchronised by the system. The first active edge after release applies normal priority.
- in, load, inc, call, ret and clr must be stable around the clock edge. There are no combinational paths from inputs to outputs.

## Configuration
- PC_STACK_EN defined: return stack, call, ret and the flags behave as above.
- PC_STACK_EN undefined: no stack storage is built, call and ret are ignored (priority becomes clr > load > inc > hold), stack_full=0, stack_empty=1, stack_err=0 constantly. Port list is unchanged.

## Test plan
- Reset/clear: rst_n=0 mid-count at out=0x0042 → out=0x0000 immediately, flags empty=1/full=0/err=0. Later, clr=1 with inc=1 at out=0x0010 → out=0x0000 next edge.
- Increment and wrap: load in=0xFFFE, then inc for 3 cycles → out 0xFFFE, 0xFFFF, 0x0000, 0x0001. err stays 0.
- Priority: load=1 and inc=1 with in=0x1234 → out=0x1234. clr+load → 0x0000. ret+load+call with sp=1 and top=0x0100 → out=0x0100, sp=0.
- Call/return: from out=0x0020, load+call in=0x0300, then inc×2, then ret → out 0x0300, 0x0301, 0x0302, 0x0021. empty toggles 1→0→1.
- Overflow/underflow (PC_STACK_EN, DEPTH=4): 5 nested calls → full=1 after the 4th. The 5th still jumps, err=1, and 4 rets return the 4 pushed addresses in LIFO order. A further ret holds out and keeps err=1. clr clears err.
- Macro off: call+load in=0x0050 → out=0x0050, empty stays 1. ret alone with inc=1 → increments. err stays 0.
